mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage. Executes MULT, MULTU, DIV and DIVU. It holds the pipeline through `stallreq` while it iterates, then presents the 64-bit result as the EX-stage HI/LO write (`ex_hi_we`/`ex_lo_we`, `ex_hi_i`/`ex_lo_i`) consumed by the HI/LO register and forwarding block. It is the sole producer of multiply/divide HI/LO results.

---
 rtl/mul_div_unit_if.sv | 23 ++
 rtl/mul_div_unit.sv | 151 +++++++++++++++
 tb/tb_mul_div_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake/result bundle between the EX stage and the mul/div unit.
// master = pipeline side, slave = mul_div_unit.
interface mul_div_unit_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stallreq;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_valid, op, src_a, src_b,
        input  stallreq, hi_we, lo_we, hi_o, lo_o
    );

    modport slave (
        input  op_valid, op, src_a, src_b,
        output stallreq, hi_we, lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for EX; stalls the pipe while busy.
// Ports: clk, rst (sync, active-high), flush, ex_stall, bus (slave):
//   op_valid/op/src_a/src_b in; stallreq, hi_we/lo_we, hi_o/lo_o out.
// MDU_FAST_MUL_EN: single-cycle array multiply instead of 32-step shift-add.
module mul_div_unit (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           ex_stall,
    mul_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        rneg_q, rneg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn_op;
    logic        accept;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] div_diff;
    logic [63:0] div_nx;
`ifdef MDU_FAST_MUL_EN
    logic [65:0] fast_p;
`else
    logic [32:0] mul_sum;
    logic [63:0] mul_nx;
`endif

    assign sgn_op = ~bus.op[0];
    assign accept = (state_q == S_IDLE) && bus.op_valid && !flush;
    assign abs_a  = (sgn_op && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    assign abs_b  = (sgn_op && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // Restoring step: trial-subtract divisor from shifted remainder.
    assign div_diff = acc_q[63:31] - {1'b0, b_q};
    assign div_nx   = div_diff[32] ? {acc_q[62:0], 1'b0}
                                   : {div_diff[31:0], acc_q[30:0], 1'b1};

`ifdef MDU_FAST_MUL_EN
    // Operands are magnitudes, so the 33-bit sign extension is zero.
    assign fast_p = {{33{1'b0}}, 1'b0, b_q} * {{33{1'b0}}, 1'b0, acc_q[31:0]};
`else
    // Shift-add: multiplier sits in acc[31:0] and drains out the bottom.
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    assign mul_nx  = {mul_sum, acc_q[31:1]};
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d  = {32'd0, abs_a};
                    b_d    = abs_b;
                    cnt_d  = 6'd0;
                    neg_d  = sgn_op & (bus.src_a[31] ^ bus.src_b[31]);
                    rneg_d = sgn_op & bus.src_a[31];
                    if (bus.op[1] && (bus.src_b == 32'd0)) begin
                        state_d = S_DONE;
                        hi_d    = bus.src_a;
                        lo_d    = 32'hFFFF_FFFF;
                    end else begin
                        state_d = bus.op[1] ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL: begin
`ifdef MDU_FAST_MUL_EN
                state_d      = S_DONE;
                {hi_d, lo_d} = neg_q ? -fast_p[63:0] : fast_p[63:0];
`else
                acc_d = mul_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d      = S_DONE;
                    {hi_d, lo_d} = neg_q ? -mul_nx : mul_nx;
                end
`endif
            end
            S_DIV: begin
                acc_d = div_nx;
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = S_DONE;
                    lo_d    = neg_q ? -div_nx[31:0] : div_nx[31:0];
                    hi_d    = rneg_q ? -div_nx[63:32] : div_nx[63:32];
                end
            end
            S_DONE: begin
                if (!ex_stall) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // Flush beats acceptance and completion; keep the old result.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= 64'd0;
            b_q     <= 32'd0;
            cnt_q   <= 6'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.stallreq = accept || (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.hi_we    = (state_q == S_DONE) && !flush;
    assign bus.lo_we    = (state_q == S_DONE) && !flush;
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: random + directed ops vs arithmetic model.
// Driver pushes expected {hi,lo}; a negedge monitor checks every HI/LO write.
module tb_mul_div_unit;

    logic clk;
    logic rst;
    logic flush;
    logic ex_stall;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .ex_stall (ex_stall),
        .bus      (bus)
    );

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_CYC = 2;
`else
    localparam int MUL_CYC = 33;
`endif

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        case (o)
            2'b00: model = sa * sb;
            2'b01: model = ua * ub;
            default: begin
                if (b == 32'd0) begin
                    model = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    model = {sr[31:0], sq[31:0]};
                end else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    model = {ur[31:0], uq[31:0]};
                end
            end
        endcase
    endfunction

    // Monitor: every write cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.hi_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_we", {bus.hi_o, bus.lo_o}, 64'hx);
            end else begin
                chk("result", {bus.hi_o, bus.lo_o}, exp_q[0]);
                chk("done_ctrl", {62'd0, bus.lo_we, bus.stallreq}, 64'd2);
                if (!ex_stall) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int sc;
        int cyc;
        int exp_sc;
        exp_sc = (o[1] && b == 32'd0) ? 1 : (o[1] ? 33 : MUL_CYC);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        ex_stall     = (hold > 0);
        exp_q.push_back(model(o, a, b));
        sc  = 0;
        cyc = 0;
        @(negedge clk);
        while (!bus.hi_we && cyc < 100) begin
            if (bus.stallreq) sc++;
            @(posedge clk);
            #1;
            cyc++;
            @(negedge clk);
        end
        chk("done_seen", {63'd0, bus.hi_we}, 64'd1);
        chk("stall_len", sc, exp_sc);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            ex_stall = (i < hold - 1);
            @(negedge clk);
        end
        chk("done_hold", {63'd0, bus.hi_we}, 64'd1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        ex_stall     = 1'b0;
        @(negedge clk);
        chk("idle_after", {62'd0, bus.hi_we, bus.stallreq}, 64'd0);
    endtask

    task automatic run_kill(input logic [1:0] o, input logic [31:0] a,
                            input logic [31:0] b, input int kill_at,
                            input bit use_rst);
        int seen;
        @(posedge clk);
        #1;
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        ex_stall     = 1'b0;
        for (int i = 0; i < kill_at; i++) begin
            @(posedge clk);
            #1;
        end
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        flush        = 1'b0;
        bus.op_valid = 1'b0;
        @(negedge clk);
        chk("kill_idle", {62'd0, bus.hi_we, bus.stallreq}, 64'd0);
        if (use_rst) chk("rst_clear", {bus.hi_o, bus.lo_o}, 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.hi_we) seen++;
        end
        chk("kill_no_we", seen, 0);
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        ex_stall     = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = 2'b00;
        bus.src_a    = 32'd0;
        bus.src_b    = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", {61'd0, bus.stallreq, bus.hi_we, bus.lo_we}, 64'd0);
        chk("reset_data", {bus.hi_o, bus.lo_o}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(2'b11, 32'd100, 32'd7, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b11, 32'h0000_1234, 32'd0, 0);
        run_op(2'b10, 32'd55, 32'd0, 1);
        run_kill(2'b10, 32'd1000, 32'd3, 10, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'b01, 32'd3, 32'd4, 5);
        run_kill(2'b11, 32'hDEAD_BEEF, 32'd9, 5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            o   = 2'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            else if (sel == 2) b = $urandom_range(1, 15);
            else if (sel == 3) a = $urandom_range(0, 1000);
            run_op(o, a, b, $urandom_range(0, 2));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
